axi_sram_slave: RTL and testbench

- Downstream neighbour of the core's AXI master interconnect: an AXI4 slave that terminates the core's single-beat load, store and instruction-fetch traffic and drives a synchronous single-port SRAM (64-bit words, byte write enables).
- Serves one transaction at a time. Arbitrates read/write contention with a fairness bit. Returns DECERR/SLVERR for illegal requests without touching the SRAM.

---
 rtl/axi_sram_slave.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI4 slave in front of a synchronous
// single-port SRAM (DATA_W-bit words, byte write enables).
// Serves one transaction at a time. A fairness bit (rd_prio) arbitrates
// read/write contention in IDLE. Illegal requests get DECERR/SLVERR and
// never touch the SRAM.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   aw*/w*/b*                AXI write address, write data, write response
//   ar*/r*                   AXI read address, read response
//   sram_en/sram_we          SRAM access strobe and write select
//   sram_addr                SRAM word address
//   sram_wstrb/sram_wdata    SRAM byte enables and write data
//   sram_rdata               SRAM read data, one cycle after a read strobe
//
// Build option: define SRAM_RDATA_REG_EN when the SRAM output carries an
// extra register stage; an RD_WAIT state then delays the read capture.
module axi_sram_slave #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_AW    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h0000_0000_8000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    // write address
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    // read address
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    // read response
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    // SRAM
    output logic                sram_en,
    output logic                sram_we,
    output logic [MEM_AW-1:0]   sram_addr,
    output logic [DATA_W/8-1:0] sram_wstrb,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_CAP, RD_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                rd_prio_q, rd_prio_d;
    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [ID_W-1:0]     bid_q, bid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                aw_fire, w_fire, ar_fire;

    // Address decode of the captured request; one address register is shared
    // by both directions since only one transaction is in flight.
    logic [ADDR_W-1:0]   off_c;
    logic                below_c, beyond_c, ok_c;
    logic [1:0]          resp_c;

    assign off_c    = addr_q - BASE_ADDR;
    assign below_c  = addr_q < BASE_ADDR;
    assign beyond_c = |off_c[ADDR_W-1:MEM_AW+3];
    assign resp_c   = (below_c || beyond_c) ? RESP_DECERR :
                      (len_q != 8'd0)       ? RESP_SLVERR : RESP_OKAY;
    assign ok_c     = (resp_c == RESP_OKAY);

    // Next-state, handshakes, SRAM strobes and capture logic.
    always_comb begin
        state_d   = state_q;
        rd_prio_d = rd_prio_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        awready   = 1'b0;
        wready    = 1'b0;
        arready   = 1'b0;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        ar_fire   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // rd_prio picks the winner only when both directions contend
                awready = !rst && !(arvalid && rd_prio_q);
                wready  = !rst && !(arvalid && rd_prio_q);
                arready = !rst && !((awvalid || wvalid) && !rd_prio_q);
            end
            WR_COLLECT: begin
                awready = !rst && !aw_held_q;
                wready  = !rst && !w_held_q;
            end
            WR_EXEC: begin
                sram_en   = ok_c;
                sram_we   = ok_c;
                bid_d     = id_q;
                bresp_d   = resp_c;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (bready) begin
                    rd_prio_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_EXEC: begin
                sram_en = ok_c;
                rid_d   = id_q;
                rresp_d = resp_c;
`ifdef SRAM_RDATA_REG_EN
                state_d = RD_WAIT;
`else
                state_d = RD_CAP;
`endif
            end
            RD_WAIT: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rdata_d = ok_c ? sram_rdata : '0;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (rready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        ar_fire = arvalid && arready;

        if (aw_fire) begin
            id_d      = awid;
            addr_d    = awaddr;
            len_d     = awlen;
            aw_held_d = 1'b1;
        end
        if (w_fire) begin
            wdata_d  = wdata;
            wstrb_d  = wstrb;
            w_held_d = 1'b1;
        end
        // AW and W may arrive in either order; the write executes the cycle
        // after the second of them is accepted.
        if (aw_fire || w_fire) begin
            if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                state_d = WR_EXEC;
            end else begin
                state_d = WR_COLLECT;
            end
        end
        if (ar_fire) begin
            id_d      = arid;
            addr_d    = araddr;
            len_d     = arlen;
            rd_prio_d = 1'b0;
            state_d   = RD_EXEC;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_prio_q <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bid_q     <= '0;
            bresp_q   <= '0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_prio_q <= rd_prio_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bvalid     = (state_q == WR_RESP);
    assign bid        = bid_q;
    assign bresp      = bresp_q;
    assign rvalid     = (state_q == RD_RESP);
    assign rlast      = (state_q == RD_RESP);
    assign rid        = rid_q;
    assign rresp      = rresp_q;
    assign rdata      = rdata_q;
    assign sram_addr  = off_c[MEM_AW+2:3];
    assign sram_wstrb = sram_we ? wstrb_q : '0;
    assign sram_wdata = wdata_q;

    // Burst shape, size and sub-word address bits play no part in a
    // single-beat full-word slave.
    logic unused_ok;
    assign unused_ok = ^{awsize, awburst, arsize, arburst, wlast, off_c[2:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed and randomized checks of axi_sram_slave
// against a reference memory and response-decode model.
module tb_axi_sram_slave;

    localparam longint unsigned BASE  = 64'h0000_0000_8000_0000;
    localparam longint unsigned WORDS = 64'd65536;
`ifdef SRAM_RDATA_REG_EN
    localparam int RL      = 4;
    localparam int CAP_OFS = 3;
`else
    localparam int RL      = 3;
    localparam int CAP_OFS = 2;
`endif

    logic        clk, rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [63:0] awaddr, araddr, wdata, rdata, sram_wdata, sram_rdata;
    logic [7:0]  awlen, arlen, wstrb, sram_wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr;

    int n_cmp = 0;
    int n_err = 0;
    logic ar_rdy_at_hs, aw_rdy_at_hs;

    bit [63:0] sram_arr [0:65535];
    bit [63:0] ref_mem  [0:65535];
    logic [63:0] rd_stage;

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM model: byte-enabled write, read data one cycle later.
    always @(posedge clk) begin
        if (sram_en && sram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_wstrb[b]) sram_arr[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
        if (sram_en && !sram_we) rd_stage <= sram_arr[sram_addr];
    end
`ifdef SRAM_RDATA_REG_EN
    logic [63:0] rd_stage2;
    always @(posedge clk) rd_stage2 <= rd_stage;
    assign sram_rdata = rd_stage2;
`else
    assign sram_rdata = rd_stage;
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [63:0] a, input logic [7:0] len);
        if (a < BASE) return 2'b11;
        if (((a - BASE) >> 3) >= WORDS) return 2'b11;
        if (len != 8'd0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [63:0] word_of(input logic [63:0] a);
        return (a - BASE) >> 3;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_txn(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [63:0] data, input logic [7:0] strb);
        logic [1:0]  er;
        logic        ok;
        logic [63:0] widx;
        int          t;
        er   = exp_resp(addr, len);
        ok   = (er == 2'b00);
        widx = word_of(addr);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b0;
        #1;
        t = 0;
        while (!(awready && wready) && t < 50) begin
            cyc();
            t++;
        end
        chk("wr_handshake", {awready, wready}, 2'b11);
        ar_rdy_at_hs = arready;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_sram", {sram_en, sram_we, sram_en ? sram_addr : 16'h0, sram_en ? sram_wstrb : 8'h0,
                        sram_en ? sram_wdata : 64'h0},
                       {ok, ok, ok ? widx[15:0] : 16'h0, ok ? strb : 8'h0, ok ? data : 64'h0});
        if (ok) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) ref_mem[widx[15:0]][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        cyc();
        chk("wr_resp", {bvalid, bid, bresp}, {1'b1, id, er});
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        chk("wr_done", bvalid, 1'b0);
    endtask

    task automatic read_txn(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int hold);
        logic [1:0]  er;
        logic        ok;
        logic [63:0] widx, exp_d;
        int          t;
        er    = exp_resp(addr, len);
        ok    = (er == 2'b00);
        widx  = word_of(addr);
        exp_d = ok ? ref_mem[widx[15:0]] : 64'h0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
        #1;
        t = 0;
        while (!arready && t < 50) begin
            cyc();
            t++;
        end
        chk("rd_handshake", arready, 1'b1);
        aw_rdy_at_hs = awready;
        cyc();
        arvalid = 1'b0;
        chk("rd_sram", {sram_en, sram_we, sram_en ? sram_addr : 16'h0},
                       {ok, 1'b0, ok ? widx[15:0] : 16'h0});
        for (int k = 2; k < RL; k++) begin
            cyc();
            chk("rd_early", rvalid, 1'b0);
        end
        cyc();
        chk("rd_resp", {rvalid, rlast, rid, rresp, rdata}, {1'b1, 1'b1, id, er, exp_d});
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("rd_hold", {rvalid, rlast, rid, rresp, rdata}, {1'b1, 1'b1, id, er, exp_d});
        end
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        chk("rd_done", rvalid, 1'b0);
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return BASE - 64'(8 * $urandom_range(1, 100)) + 64'($urandom_range(0, 7));
        if (r == 1) return BASE + WORDS * 8 + 64'(8 * $urandom_range(0, 100));
        if (r == 2) return BASE + (WORDS - 1) * 8 + 64'($urandom_range(0, 7));
        return BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [63:0] ra;
        logic [7:0]  rl;
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b1; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        ar_rdy_at_hs = 1'b0; aw_rdy_at_hs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {awready, wready, arready}, 3'b000);
        chk("reset_outs", {bvalid, rvalid, rlast, sram_en, sram_we, bid, bresp, rid, rresp, rdata}, 0);
        rst = 1'b0;
        cyc();
        chk("idle_ready", {awready, wready, arready}, 3'b111);

        // Contention from reset: write first, then the waiting read (rready held low)
        arid = 4'd5; araddr = BASE + 64'h10; arlen = 8'd0; arvalid = 1'b1;
        write_txn(4'd3, BASE + 64'h10, 8'd0, 64'h1122334455667788, 8'hFF);
        chk("cont1_ar_blocked", ar_rdy_at_hs, 1'b0);
        read_txn(4'd5, BASE + 64'h10, 8'd0, 3);

        // Split write: W two cycles ahead of AW, low four bytes only
        wdata = 64'hAABBCCDDEEFF0011; wstrb = 8'h0F; wvalid = 1'b1;
        #1;
        chk("split_w_ready", wready, 1'b1);
        cyc();
        wvalid = 1'b0;
        #1;
        chk("collect_ready", {awready, wready, arready}, 3'b100);
        cyc();
        chk("collect_no_sram", sram_en, 1'b0);
        awid = 4'd4; awaddr = BASE + 64'h10; awlen = 8'd0; awvalid = 1'b1;
        #1;
        chk("split_aw_ready", awready, 1'b1);
        cyc();
        awvalid = 1'b0;
        chk("split_sram", {sram_en, sram_we, sram_addr, sram_wstrb, sram_wdata},
                          {1'b1, 1'b1, 16'd2, 8'h0F, 64'hAABBCCDDEEFF0011});
        for (int b = 0; b < 4; b++) ref_mem[2][b*8 +: 8] = wdata[b*8 +: 8];
        cyc();
        chk("split_bresp", {bvalid, bid, bresp}, {1'b1, 4'd4, 2'b00});
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        read_txn(4'd6, BASE + 64'h10, 8'd0, 0);

        // Error responses
        read_txn(4'd7, 64'h7FFF_FFF8, 8'd0, 1);
        write_txn(4'd8, BASE + 64'h40, 8'd3, 64'hDEADBEEFCAFEF00D, 8'hFF);
        read_txn(4'd8, BASE + 64'h40, 8'd0, 0);

        // Top of the mapped window and the first word past it
        write_txn(4'd9, BASE + (WORDS - 1) * 8, 8'd0, 64'h0123456789ABCDEF, 8'hF0);
        read_txn(4'd9, BASE + (WORDS - 1) * 8, 8'd0, 0);
        write_txn(4'd10, BASE + WORDS * 8, 8'd0, 64'h5555AAAA5555AAAA, 8'hFF);
        read_txn(4'd10, BASE + WORDS * 8, 8'd0, 0);

        // Read priority after a write: simultaneous pair serves the read first
        write_txn(4'd1, BASE + 64'h18, 8'd0, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
        awid = 4'd2; awaddr = BASE + 64'h18; awlen = 8'd0; awvalid = 1'b1;
        wdata = 64'h7777666655554444; wstrb = 8'hFF; wvalid = 1'b1;
        read_txn(4'd12, BASE + 64'h18, 8'd0, 0);
        chk("cont2_aw_blocked", aw_rdy_at_hs, 1'b0);
        write_txn(4'd2, BASE + 64'h18, 8'd0, 64'h7777666655554444, 8'hFF);
        read_txn(4'd13, BASE + 64'h18, 8'd0, 0);

        // Reset while the read sits in RD_CAP drops it
        arid = 4'd11; araddr = BASE + 64'h10; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
        #1;
        chk("rst_ar_ready", arready, 1'b1);
        cyc();
        arvalid = 1'b0;
        for (int k = 1; k < CAP_OFS; k++) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_mid_rvalid", {rvalid, rdata, rresp}, 0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_no_resp", rvalid, 1'b0);
        end
        rready = 1'b0;
        read_txn(4'd14, BASE + 64'h10, 8'd0, 0);

        // Randomized traffic over a small window plus out-of-range addresses
        for (int i = 0; i < 60; i++) begin
            ra = rand_addr();
            rl = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            if ($urandom_range(0, 1) == 1)
                write_txn(4'($urandom_range(0, 15)), ra, rl, {$urandom, $urandom}, 8'($urandom));
            else
                read_txn(4'($urandom_range(0, 15)), ra, rl, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
